hazard_sequencer: RTL and testbench

Pipeline stall/flush sequencer for the 5-stage RISC-V core. Consumes the load-use hazard flag from forwarding control, the execute-stage branch decision and the data-memory handshake, and drives per-stage register enables and flushes. A small FSM guarantees a load-use bubble is inserted exactly once and freezes the whole pipe across data-memory wait states, with a timeout trap.

---
 rtl/hazard_sequencer.sv | 141 ++++++++++++++
 tb/tb_hazard_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer: load-use bubble, branch flush, dmem wait freeze, timeout trap.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu_hazard,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    MEM_WAIT  = 2'd2,
    TRAP      = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LIM = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_q;
  logic [7:0] wait_d;

  logic [4:0] en;
  logic       fl_if;
  logic       fl_id;
  logic       trap;
  logic       miss;
  logic       done;

  assign miss = dmem_req & ~dmem_ready;
  assign done = dmem_req & dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    en      = 5'b11111;
    fl_if   = 1'b0;
    fl_id   = 1'b0;
    trap    = 1'b0;
    unique case (state_q)
      RUN, LU_BUBBLE: begin
        state_d = RUN;
        if (miss) begin
          en      = 5'b00000;
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end else if (br_taken) begin
          fl_if = 1'b1;
          fl_id = 1'b1;
        end else if (lu_hazard && state_q == RUN) begin
          // hold PC and IF/ID, push a bubble into ID/EX
          en      = 5'b00111;
          fl_id   = 1'b1;
          state_d = LU_BUBBLE;
        end
      end
      MEM_WAIT: begin
        en = 5'b00000;
        if (done) begin
          en      = 5'b11111;
          state_d = RUN;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LIM) begin
          state_d = TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      TRAP: begin
        en   = 5'b00000;
        trap = 1'b1;
      end
      default: begin
        state_d = RUN;
        wait_d  = 8'd0;
      end
    endcase
    if (rst) begin
      en    = 5'b00000;
      fl_if = 1'b1;
      fl_id = 1'b1;
      trap  = 1'b0;
    end
  end

  assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = en;
  assign ifid_flush  = fl_if;
  assign idex_flush  = fl_id;
  assign mem_timeout = trap;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      // outside reset ifid_flush only comes from a taken branch
      if (ifid_flush && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (MEM_TIMEOUT=4).
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_sequencer;

  logic        clk;
  logic        rst;
  logic        lu_hazard;
  logic        br_taken;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, mem_timeout;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
  logic [7:0]  ctl;

  int run;
  int failed;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  hazard_sequencer #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .lu_hazard    (lu_hazard),
    .br_taken     (br_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .idex_en      (idex_en),
    .exmem_en     (exmem_en),
    .memwb_en     (memwb_en),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  // {pc,ifid,idex,exmem,memwb, ifid_flush, idex_flush, mem_timeout}
  assign ctl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, mem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    lu_hazard  = 1'b0;
    br_taken   = 1'b0;
    dmem_req   = 1'b0;
    dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    run++;
    if (ctl !== 8'b00000_110) begin
      failed++;
      $display("FAIL rst_ctl got %b want %b", ctl, 8'b00000_110);
    end
    run++;
    if (stall_cycles !== 0 || flush_events !== 0) begin
      failed++;
      $display("FAIL rst_cnt got %0d/%0d want 0/0", stall_cycles, flush_events);
    end
    rst = 1'b0;
    #1;
    run++;
    if (ctl !== 8'b11111_000) begin
      failed++;
      $display("FAIL rst_release got %b want %b", ctl, 8'b11111_000);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    lu_hazard = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b00111_010) begin
      failed++;
      $display("FAIL lu_c1 got %b want %b", ctl, 8'b00111_010);
    end
    @(negedge clk);
    #1;
    run++;
    if (ctl !== 8'b11111_000) begin
      failed++;
      $display("FAIL lu_c2 got %b want %b", ctl, 8'b11111_000);
    end
    @(negedge clk);
    lu_hazard = 1'b0;
    #1;
    run++;
    if (ctl !== 8'b11111_000) begin
      failed++;
      $display("FAIL lu_c3 got %b want %b", ctl, 8'b11111_000);
    end
    run++;
    if (stall_cycles !== 32'(PERF) || flush_events !== 0) begin
      failed++;
      $display("FAIL lu_cnt got %0d/%0d want %0d/0",
               stall_cycles, flush_events, PERF);
    end
  endtask

  task automatic test_branch_lu();
    do_reset();
    br_taken  = 1'b1;
    lu_hazard = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b11111_110) begin
      failed++;
      $display("FAIL br_lu got %b want %b", ctl, 8'b11111_110);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    run++;
    if (ctl !== 8'b11111_000) begin
      failed++;
      $display("FAIL br_after got %b want %b", ctl, 8'b11111_000);
    end
    run++;
    if (flush_events !== 32'(PERF) || stall_cycles !== 0) begin
      failed++;
      $display("FAIL br_cnt got %0d/%0d want 0/%0d",
               stall_cycles, flush_events, PERF);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b00000_000) begin
      failed++;
      $display("FAIL mw_c1 got %b want %b", ctl, 8'b00000_000);
    end
    @(negedge clk);
    br_taken  = 1'b1;
    lu_hazard = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b00000_000) begin
      failed++;
      $display("FAIL mw_c2_br got %b want %b", ctl, 8'b00000_000);
    end
    @(negedge clk);
    br_taken  = 1'b0;
    lu_hazard = 1'b0;
    #1;
    run++;
    if (ctl !== 8'b00000_000) begin
      failed++;
      $display("FAIL mw_c3 got %b want %b", ctl, 8'b00000_000);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b11111_000) begin
      failed++;
      $display("FAIL mw_done got %b want %b", ctl, 8'b11111_000);
    end
    @(negedge clk);
    dmem_req = 1'b0;
    #1;
    run++;
    if (ctl !== 8'b11111_000) begin
      failed++;
      $display("FAIL mw_run got %b want %b", ctl, 8'b11111_000);
    end
    run++;
    if (stall_cycles !== (PERF ? 32'd3 : 32'd0) || flush_events !== 0) begin
      failed++;
      $display("FAIL mw_cnt got %0d/%0d want %0d/0",
               stall_cycles, flush_events, PERF ? 3 : 0);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    dmem_req   = 1'b1;
    dmem_ready = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b11111_000) begin
      failed++;
      $display("FAIL zw_hit got %b want %b", ctl, 8'b11111_000);
    end
    @(negedge clk);
    dmem_req = 1'b0;
    lu_hazard = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b00111_010) begin
      failed++;
      $display("FAIL zw_ready_only got %b want %b", ctl, 8'b00111_010);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_bubble_branch();
    do_reset();
    lu_hazard = 1'b1;
    @(negedge clk);
    br_taken = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b11111_110) begin
      failed++;
      $display("FAIL bub_br got %b want %b", ctl, 8'b11111_110);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    run++;
    if (stall_cycles !== 32'(PERF) || flush_events !== 32'(PERF)) begin
      failed++;
      $display("FAIL bub_br_cnt got %0d/%0d want %0d/%0d",
               stall_cycles, flush_events, PERF, PERF);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lu_hazard = 1'b1;
    @(negedge clk);
    lu_hazard = 1'b0;
    dmem_req  = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b00000_000) begin
      failed++;
      $display("FAIL b2b_miss got %b want %b", ctl, 8'b00000_000);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b11111_000) begin
      failed++;
      $display("FAIL b2b_done got %b want %b", ctl, 8'b11111_000);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    run++;
    if (stall_cycles !== (PERF ? 32'd2 : 32'd0)) begin
      failed++;
      $display("FAIL b2b_cnt got %0d want %0d", stall_cycles, PERF ? 2 : 0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      run++;
      if (ctl !== 8'b00000_000) begin
        failed++;
        $display("FAIL to_wait%0d got %b want %b", i, ctl, 8'b00000_000);
      end
      @(negedge clk);
    end
    #1;
    run++;
    if (ctl !== 8'b00000_001) begin
      failed++;
      $display("FAIL to_trap got %b want %b", ctl, 8'b00000_001);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b00000_001) begin
      failed++;
      $display("FAIL to_sticky got %b want %b", ctl, 8'b00000_001);
    end
    run++;
    if (stall_cycles !== (PERF ? 32'd5 : 32'd0)) begin
      failed++;
      $display("FAIL to_cnt got %0d want %0d", stall_cycles, PERF ? 5 : 0);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    run++;
    if (ctl !== 8'b00000_110) begin
      failed++;
      $display("FAIL to_rst got %b want %b", ctl, 8'b00000_110);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    run++;
    if (ctl !== 8'b11111_000 || stall_cycles !== 0) begin
      failed++;
      $display("FAIL to_recover got %b/%0d want %b/0",
               ctl, stall_cycles, 8'b11111_000);
    end
  endtask

  initial begin
    run    = 0;
    failed = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_zero_wait();
    test_bubble_branch();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", run, failed);
    $finish;
  end

endmodule
